// File: rtl/drum_dot8_pkg.sv
// Shared constants and types for the eight-lane DRUM dot-product unit.
package drum_pkg;

   localparam int DATA_W = 16;
   localparam int K      = 6;
   localparam int N      = 8;
   localparam int OUT_W  = 2 * DATA_W + 3;
   localparam int PROD_W = 2 * DATA_W;
   localparam int SH_W   = $clog2(DATA_W);

   // One approximated operand: K-bit segment plus the shift that restores it.
   typedef struct packed {
      logic [K-1:0]    seg;
      logic [SH_W-1:0] sh;
   } drum_seg_t;

endpackage

// File: rtl/drum_dot8_if.sv
// Operand/result bundle of the dot-product unit.
// There is no handshake: operands are sampled on every rising clock edge,
// and Out_OFM holds the sum of the operands seen at the previous edge.
interface drum_dot8_if;
   import drum_pkg::*;

   logic [DATA_W-1:0] In_IFM_1;
   logic [DATA_W-1:0] In_IFM_2;
   logic [DATA_W-1:0] In_IFM_3;
   logic [DATA_W-1:0] In_IFM_4;
   logic [DATA_W-1:0] In_IFM_5;
   logic [DATA_W-1:0] In_IFM_6;
   logic [DATA_W-1:0] In_IFM_7;
   logic [DATA_W-1:0] In_IFM_8;
   logic [DATA_W-1:0] In_Weight_1;
   logic [DATA_W-1:0] In_Weight_2;
   logic [DATA_W-1:0] In_Weight_3;
   logic [DATA_W-1:0] In_Weight_4;
   logic [DATA_W-1:0] In_Weight_5;
   logic [DATA_W-1:0] In_Weight_6;
   logic [DATA_W-1:0] In_Weight_7;
   logic [DATA_W-1:0] In_Weight_8;
   logic [OUT_W-1:0]  Out_OFM;

   // Producer of operands, consumer of the result.
   modport master (
      output In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4,
             In_IFM_5, In_IFM_6, In_IFM_7, In_IFM_8,
             In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4,
             In_Weight_5, In_Weight_6, In_Weight_7, In_Weight_8,
      input  Out_OFM
   );

   // The dot-product unit itself.
   modport slave (
      input  In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4,
             In_IFM_5, In_IFM_6, In_IFM_7, In_IFM_8,
             In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4,
             In_Weight_5, In_Weight_6, In_Weight_7, In_Weight_8,
      output Out_OFM
   );

endinterface

// File: rtl/drum_dot8_mul.sv
// One DRUM lane: approximates both operands to K-bit segments, multiplies
// the segments exactly and shifts the product back to full scale.
module drum_mul
   import drum_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [PROD_W-1:0] prod_o
);

   // Small operands pass through untouched; larger ones keep the K bits
   // below and including the leading one, with the LSB forced high so the
   // truncation error is centred on zero instead of always negative.
   function automatic drum_seg_t approx(input logic [DATA_W-1:0] x);
      drum_seg_t         r;
      int                lead;
      logic [DATA_W-1:0] shifted;
      lead    = 0;
      for (int i = 0; i < DATA_W; i++) begin
         if (x[i]) lead = i;
      end
      r.seg   = x[K-1:0];
      r.sh    = '0;
      shifted = x;
      if (lead >= K) begin
         r.sh    = SH_W'(lead - K + 1);
         shifted = x >> r.sh;
         r.seg   = shifted[K-1:0] | {{(K-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   drum_seg_t             seg_a;
   drum_seg_t             seg_b;
   logic [2*K-1:0]        seg_prod;
   logic [SH_W:0]         sh_sum;

   // Leading-one detection and segment extraction for both operands.
   always_comb begin
      seg_a = approx(a_i);
      seg_b = approx(b_i);
   end

   // Exact KxK multiply followed by the barrel shift back to 2*DATA_W bits.
   always_comb begin
      seg_prod = {{K{1'b0}}, seg_a.seg} * {{K{1'b0}}, seg_b.seg};
      sh_sum   = {1'b0, seg_a.sh} + {1'b0, seg_b.sh};
      prod_o   = {{(PROD_W-2*K){1'b0}}, seg_prod} << sh_sum;
   end

endmodule

// File: rtl/drum_dot8.sv
// Eight-lane DRUM dot product: eight approximate lane products are summed
// exactly and the sum is registered once per clock (one-cycle latency).
module drum_dot8
   import drum_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   drum_dot8_if.slave  bus
);

   logic [DATA_W-1:0] ifm   [N];
   logic [DATA_W-1:0] wgt   [N];
   logic [PROD_W-1:0] prod  [N];
   logic [OUT_W-1:0]  lvl1  [4];
   logic [OUT_W-1:0]  lvl2  [2];
   logic [OUT_W-1:0]  ofm_d;
   logic [OUT_W-1:0]  ofm_q;

   // Gather the individually named lanes into arrays for the lane loop.
   always_comb begin
      ifm[0] = bus.In_IFM_1;    wgt[0] = bus.In_Weight_1;
      ifm[1] = bus.In_IFM_2;    wgt[1] = bus.In_Weight_2;
      ifm[2] = bus.In_IFM_3;    wgt[2] = bus.In_Weight_3;
      ifm[3] = bus.In_IFM_4;    wgt[3] = bus.In_Weight_4;
      ifm[4] = bus.In_IFM_5;    wgt[4] = bus.In_Weight_5;
      ifm[5] = bus.In_IFM_6;    wgt[5] = bus.In_Weight_6;
      ifm[6] = bus.In_IFM_7;    wgt[6] = bus.In_Weight_7;
      ifm[7] = bus.In_IFM_8;    wgt[7] = bus.In_Weight_8;
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      drum_mul u_mul (
         .a_i    (ifm[g]),
         .b_i    (wgt[g]),
         .prod_o (prod[g])
      );
   end

   // Balanced three-level adder tree; OUT_W bits leave room for 8 full-scale
   // products, so no saturation or wrap handling is needed.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lvl1[i] = OUT_W'(prod[2*i]) + OUT_W'(prod[2*i+1]);
      end
      for (int i = 0; i < 2; i++) begin
         lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
      end
      ofm_d = lvl2[0] + lvl2[1];
   end

   // Output register, cleared asynchronously while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ofm_q <= '0;
      else        ofm_q <= ofm_d;
   end

   assign bus.Out_OFM = ofm_q;

endmodule

// File: tb/tb_drum_dot8.sv
// Self-checking bench for drum_dot8: directed spec vectors, an asynchronous
// reset check and randomized back-to-back traffic against a DRUM model.
module tb_drum_dot8;
   import drum_pkg::*;

   logic clk;
   logic rst_n;
   drum_dot8_if bus ();

   drum_dot8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned      n_checks;
   int unsigned      n_errors;
   logic [OUT_W-1:0] exp_q [$];
   string            tag_q [$];
   logic [15:0]      ifm_v [8];
   logic [15:0]      wgt_v [8];

   task automatic check_eq(input string tag, input logic [OUT_W-1:0] got,
                           input logic [OUT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference: DRUM approximation from plain arithmetic on the operand value.
   function automatic void approx(input int unsigned x, output longint unsigned seg,
                                  output int unsigned sh);
      int unsigned t;
      if (x < (1 << K)) begin
         seg = x;
         sh  = 0;
      end else begin
         t   = $clog2(x + 1) - 1;
         sh  = t - K + 1;
         seg = (x >> sh) | 1;
      end
   endfunction

   function automatic longint unsigned model_sum();
      longint unsigned acc, sa_seg, sb_seg;
      int unsigned     sa, sb;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         approx(ifm_v[i], sa_seg, sa);
         approx(wgt_v[i], sb_seg, sb);
         acc += (sa_seg * sb_seg) << (sa + sb);
      end
      return acc;
   endfunction

   task automatic drive_bus();
      bus.In_IFM_1 = ifm_v[0];  bus.In_Weight_1 = wgt_v[0];
      bus.In_IFM_2 = ifm_v[1];  bus.In_Weight_2 = wgt_v[1];
      bus.In_IFM_3 = ifm_v[2];  bus.In_Weight_3 = wgt_v[2];
      bus.In_IFM_4 = ifm_v[3];  bus.In_Weight_4 = wgt_v[3];
      bus.In_IFM_5 = ifm_v[4];  bus.In_Weight_5 = wgt_v[4];
      bus.In_IFM_6 = ifm_v[5];  bus.In_Weight_6 = wgt_v[5];
      bus.In_IFM_7 = ifm_v[6];  bus.In_Weight_7 = wgt_v[6];
      bus.In_IFM_8 = ifm_v[7];  bus.In_Weight_8 = wgt_v[7];
   endtask

   task automatic fill(input logic [15:0] a, input logic [15:0] b);
      for (int i = 0; i < 8; i++) begin
         ifm_v[i] = a;
         wgt_v[i] = b;
      end
   endtask

   // One vector per cycle: drive at negedge, check the result after the edge.
   task automatic apply(input string tag, input logic [OUT_W-1:0] exp);
      @(negedge clk);
      drive_bus();
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      check_eq(tag_q.pop_front(), bus.Out_OFM, exp_q.pop_front());
   endtask

   task automatic apply_model(input string tag);
      apply(tag, OUT_W'(model_sum()));
   endtask

   function automatic logic [15:0] rand_operand();
      case ($urandom_range(0, 4))
         0:       return 16'($urandom_range(0, 63));
         1:       return 16'($urandom_range(60, 140));
         2:       return 16'($urandom_range(0, 65535));
         3:       return 16'(16'hFFFF >> $urandom_range(0, 15));
         default: return 16'($urandom_range(0, 1) ? 0 : $urandom_range(0, 65535));
      endcase
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      fill(16'd0, 16'd0);
      drive_bus();
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_initial", bus.Out_OFM, '0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, back to back.
      fill(16'd63, 16'd63);
      apply("exact_63x63", 35'd31752);
      fill(16'd0, 16'd0); ifm_v[0] = 16'd1000; wgt_v[0] = 16'd1;
      apply("approx_1000x1", 35'd1008);
      fill(16'd0, 16'd0); ifm_v[0] = 16'd64; wgt_v[0] = 16'd64;
      apply("boundary_64x64", 35'd4356);
      fill(16'd0, 16'd0); ifm_v[0] = 16'd63; wgt_v[0] = 16'd64;
      apply("boundary_63x64", 35'd4158);
      fill(16'hFFFF, 16'hFFFF);
      apply("full_scale", 35'd33294385152);
      fill(16'd0, 16'hFFFF);
      apply("zero_ifm", 35'd0);
      fill(16'd0, 16'd0); ifm_v[7] = 16'd1000; wgt_v[7] = 16'd1;
      apply("lane8_1000x1", 35'd1008);
      fill(16'd63, 16'd63);
      apply("exact_again", 35'd31752);

      // Asynchronous reset in the middle of the high phase.
      fill(16'hFFFF, 16'hFFFF);
      apply("pre_reset_full", 35'd33294385152);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("reset_async_immediate", bus.Out_OFM, '0);
      @(posedge clk);
      #1;
      check_eq("reset_held_over_edge", bus.Out_OFM, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("reset_released_before_edge", bus.Out_OFM, '0);
      @(posedge clk);
      #1;
      check_eq("first_after_release", bus.Out_OFM, 35'd33294385152);

      // Randomized back-to-back traffic against the model.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 8; i++) begin
            ifm_v[i] = rand_operand();
            wgt_v[i] = rand_operand();
         end
         apply_model("random");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
